// File: rtl/instr_bus_pkg.sv
// Shared types for the instruction fetch bus.
// Response payload travels as {err, rdata}.
package instr_bus_pkg;

    localparam int WORD_BYTES = 4;
    localparam int ADDR_W     = 32;
    localparam int DATA_W     = 32;

    typedef struct packed {
        logic              err;
        logic [DATA_W-1:0] rdata;
    } instr_rsp_t;

endpackage

// File: rtl/instr_rsp_delay_line.sv
// Fixed-latency valid/payload shift register for fetch responses.
// Payload only moves with a valid entry, so the tail holds its last response.
module instr_rsp_delay_line
    import instr_bus_pkg::*;
#(
    parameter int LATENCY = 1
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       in_valid,
    input  instr_rsp_t in_rsp,
    output logic       out_valid,
    output instr_rsp_t out_rsp
);

    logic [LATENCY-1:0] vld_q;
    instr_rsp_t         rsp_q [LATENCY];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            vld_q <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                rsp_q[i] <= '0;
            end
        end else begin
            vld_q[0] <= in_valid;
            if (in_valid) begin
                rsp_q[0] <= in_rsp;
            end
            for (int i = 1; i < LATENCY; i++) begin
                vld_q[i] <= vld_q[i-1];
                if (vld_q[i-1]) begin
                    rsp_q[i] <= rsp_q[i-1];
                end
            end
        end
    end

    assign out_valid = vld_q[LATENCY-1];
    assign out_rsp   = rsp_q[LATENCY-1];

endmodule

// File: rtl/instr_mem_responder.sv
// Memory-side responder for the instruction fetch bus with
// fixed read latency, outstanding limit and optional grant gaps.
module instr_mem_responder
    import instr_bus_pkg::*;
#(
    parameter int          MEM_WORDS       = 1024,
    parameter logic [31:0] BASE_ADDR       = 32'h0,
    parameter int          LATENCY         = 1,
    parameter int          MAX_OUTSTANDING = 2,
    parameter int          GNT_GAP_PERIOD  = 0,
    parameter string       INIT_FILE       = ""
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              instr_req_i,
    output logic              instr_gnt_o,
    input  logic [ADDR_W-1:0] instr_addr_i,
    output logic [DATA_W-1:0] instr_rdata_o,
    output logic              instr_err_o,
    output logic              instr_rvalid_o,
    input  logic              load_we_i,
    input  logic [ADDR_W-1:0] load_addr_i,
    input  logic [DATA_W-1:0] load_wdata_i,
    output logic [2:0]        outstanding_o
);

    localparam int         IDX_W   = $clog2(MEM_WORDS);
    localparam logic [2:0] MAX_OUT = 3'(MAX_OUTSTANDING);

    if (LATENCY < 1 || LATENCY > 4) begin : g_bad_latency
        $error("instr_mem_responder: LATENCY must be 1..4");
    end
    if (MAX_OUTSTANDING < 1 || MAX_OUTSTANDING > LATENCY + 1) begin : g_bad_max
        $error("instr_mem_responder: MAX_OUTSTANDING must be 1..LATENCY+1");
    end
    if (MEM_WORDS < 2 || (MEM_WORDS & (MEM_WORDS - 1)) != 0 || IDX_W > 29) begin : g_bad_words
        $error("instr_mem_responder: MEM_WORDS must be a power of 2");
    end
    if (BASE_ADDR[1:0] != 2'b00) begin : g_bad_base
        $error("instr_mem_responder: BASE_ADDR must be word aligned");
    end

    logic [DATA_W-1:0] mem [MEM_WORDS];

    logic [ADDR_W-1:0] fetch_off;
    logic [ADDR_W-1:0] load_off;
    logic              fetch_err;
    logic              load_ok;
    logic [IDX_W-1:0]  fetch_idx;
    logic [IDX_W-1:0]  load_idx;

    assign fetch_off = instr_addr_i - BASE_ADDR;
    assign load_off  = load_addr_i - BASE_ADDR;
    assign fetch_idx = fetch_off[IDX_W+1:2];
    assign load_idx  = load_off[IDX_W+1:2];
    assign fetch_err = (fetch_off[1:0] != 2'b00)
                    || (fetch_off[ADDR_W-1:IDX_W+2] != '0);
    assign load_ok   = (load_off[1:0] == 2'b00)
                    && (load_off[ADDR_W-1:IDX_W+2] == '0);

    logic       ready_q;
    logic       gap_q;
    logic [2:0] out_q;
    logic [2:0] out_live;
    logic       gnt_ok;
    logic       accept;
    logic       rsp_valid;
    instr_rsp_t rsp_in;
    instr_rsp_t rsp_out;

    // A response leaving this cycle frees its slot for a same-cycle accept.
    assign out_live = out_q - {2'b00, rsp_valid};
    assign gnt_ok   = ready_q && !gap_q && (out_live < MAX_OUT);
    assign accept   = instr_req_i && gnt_ok;

    always_comb begin
        rsp_in.err   = fetch_err;
        rsp_in.rdata = '0;
        if (!fetch_err) begin
            rsp_in.rdata = mem[fetch_idx];
        end
    end

    // Array is not reset so a program image survives rstn.
    always_ff @(posedge clk) begin
        if (load_we_i && load_ok) begin
            mem[load_idx] <= load_wdata_i;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ready_q <= 1'b0;
            out_q   <= '0;
        end else begin
            ready_q <= 1'b1;
            out_q   <= out_q + {2'b00, accept} - {2'b00, rsp_valid};
        end
    end

    if (GNT_GAP_PERIOD > 0) begin : g_gap
        localparam int GAP_W = (GNT_GAP_PERIOD > 1) ? $clog2(GNT_GAP_PERIOD) : 1;
        localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GNT_GAP_PERIOD - 1);
        logic [GAP_W-1:0] gap_cnt_q;

        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                gap_cnt_q <= '0;
                gap_q     <= 1'b0;
            end else begin
                gap_q <= 1'b0;
                if (accept) begin
                    if (gap_cnt_q == GAP_LAST) begin
                        gap_cnt_q <= '0;
                        gap_q     <= 1'b1;
                    end else begin
                        gap_cnt_q <= gap_cnt_q + 1'b1;
                    end
                end
            end
        end
    end else begin : g_no_gap
        assign gap_q = 1'b0;
    end

    instr_rsp_delay_line #(
        .LATENCY (LATENCY)
    ) u_delay (
        .clk       (clk),
        .rstn      (rstn),
        .in_valid  (accept),
        .in_rsp    (rsp_in),
        .out_valid (rsp_valid),
        .out_rsp   (rsp_out)
    );

    assign instr_gnt_o    = accept;
    assign instr_rvalid_o = rsp_valid;
    assign instr_rdata_o  = rsp_out.rdata;
    assign instr_err_o    = rsp_out.err && rsp_valid;
    assign outstanding_o  = out_q;

endmodule

// File: tb/tb_instr_mem_responder.sv
// Directed bench for instr_mem_responder: three instances cover
// latency 1, latency 3 with outstanding limit, and grant gaps.
module tb_instr_mem_responder;

    logic clk = 1'b0;
    logic rstn;

    always #5 clk = ~clk;

    logic        a_req, a_gnt, a_err, a_rvalid, a_we;
    logic [31:0] a_addr, a_rdata, a_laddr, a_wdata;
    logic [2:0]  a_out;

    logic        b_req, b_gnt, b_err, b_rvalid, b_we;
    logic [31:0] b_addr, b_rdata, b_laddr, b_wdata;
    logic [2:0]  b_out;

    logic        c_req, c_gnt, c_err, c_rvalid, c_we;
    logic [31:0] c_addr, c_rdata, c_laddr, c_wdata;
    logic [2:0]  c_out;

    instr_mem_responder u_dut_a (
        .clk(clk), .rstn(rstn),
        .instr_req_i(a_req), .instr_gnt_o(a_gnt), .instr_addr_i(a_addr),
        .instr_rdata_o(a_rdata), .instr_err_o(a_err), .instr_rvalid_o(a_rvalid),
        .load_we_i(a_we), .load_addr_i(a_laddr), .load_wdata_i(a_wdata),
        .outstanding_o(a_out)
    );

    instr_mem_responder #(.LATENCY(3), .MAX_OUTSTANDING(2)) u_dut_b (
        .clk(clk), .rstn(rstn),
        .instr_req_i(b_req), .instr_gnt_o(b_gnt), .instr_addr_i(b_addr),
        .instr_rdata_o(b_rdata), .instr_err_o(b_err), .instr_rvalid_o(b_rvalid),
        .load_we_i(b_we), .load_addr_i(b_laddr), .load_wdata_i(b_wdata),
        .outstanding_o(b_out)
    );

    instr_mem_responder #(.GNT_GAP_PERIOD(2)) u_dut_c (
        .clk(clk), .rstn(rstn),
        .instr_req_i(c_req), .instr_gnt_o(c_gnt), .instr_addr_i(c_addr),
        .instr_rdata_o(c_rdata), .instr_err_o(c_err), .instr_rvalid_o(c_rvalid),
        .load_we_i(c_we), .load_addr_i(c_laddr), .load_wdata_i(c_wdata),
        .outstanding_o(c_out)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic a_set(input logic req, input logic [31:0] addr,
                         input logic we, input logic [31:0] la,
                         input logic [31:0] wd);
        a_req = req; a_addr = addr; a_we = we; a_laddr = la; a_wdata = wd;
    endtask

    task automatic b_set(input logic req, input logic [31:0] addr,
                         input logic we, input logic [31:0] la,
                         input logic [31:0] wd);
        b_req = req; b_addr = addr; b_we = we; b_laddr = la; b_wdata = wd;
    endtask

    logic [5:0]  gap_pat;
    logic [31:0] exp_b [3];
    int          n_acc;
    int          n_rsp;
    int          n_stale;

    initial begin
        rstn = 1'b0;
        a_set(1'b1, 32'h0, 1'b0, 32'h0, 32'h0);
        b_set(1'b1, 32'h0, 1'b0, 32'h0, 32'h0);
        c_req = 1'b1; c_addr = 32'h0; c_we = 1'b0;
        c_laddr = 32'h0; c_wdata = 32'h0;

        // reset state
        @(negedge clk); #1;
        check("rst_gnt", 32'(a_gnt), 32'd0);
        check("rst_rvalid", 32'(a_rvalid), 32'd0);
        check("rst_err", 32'(a_err), 32'd0);
        check("rst_rdata", a_rdata, 32'h0);
        check("rst_out", 32'(a_out), 32'd0);
        check("rst_gnt_b", 32'(b_gnt), 32'd0);

        @(negedge clk);
        rstn = 1'b1;
        a_set(1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
        b_set(1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
        c_req = 1'b0;

        // single read, latency 1
        @(negedge clk); a_set(1'b0, 32'h0, 1'b1, 32'h0, 32'h13); #1;
        @(negedge clk); a_set(1'b1, 32'h0, 1'b0, 32'h0, 32'h0); #1;
        check("t1_gnt", 32'(a_gnt), 32'd1);
        @(negedge clk); a_set(1'b0, 32'h0, 1'b0, 32'h0, 32'h0); #1;
        check("t1_rvalid", 32'(a_rvalid), 32'd1);
        check("t1_rdata", a_rdata, 32'h13);
        check("t1_err", 32'(a_err), 32'd0);
        check("t1_out", 32'(a_out), 32'd1);
        @(negedge clk); #1;
        check("t1_idle_rvalid", 32'(a_rvalid), 32'd0);
        check("t1_hold_rdata", a_rdata, 32'h13);
        check("t1_idle_out", 32'(a_out), 32'd0);

        // error responses: misaligned and past the array end
        @(negedge clk); a_set(1'b1, 32'h2, 1'b0, 32'h0, 32'h0); #1;
        check("t3_gnt0", 32'(a_gnt), 32'd1);
        @(negedge clk); a_set(1'b1, 32'h1000, 1'b0, 32'h0, 32'h0); #1;
        check("t3_gnt1", 32'(a_gnt), 32'd1);
        check("t3_rv0", 32'(a_rvalid), 32'd1);
        check("t3_err0", 32'(a_err), 32'd1);
        check("t3_rdata0", a_rdata, 32'h0);
        @(negedge clk); a_set(1'b0, 32'h0, 1'b0, 32'h0, 32'h0); #1;
        check("t3_rv1", 32'(a_rvalid), 32'd1);
        check("t3_err1", 32'(a_err), 32'd1);
        check("t3_rdata1", a_rdata, 32'h0);
        @(negedge clk); #1;
        check("t3_err_idle", 32'(a_err), 32'd0);
        check("t3_out", 32'(a_out), 32'd0);

        // read-before-write on the same word; misaligned load ignored
        @(negedge clk); a_set(1'b0, 32'h0, 1'b1, 32'h10, 32'h0); #1;
        @(negedge clk); a_set(1'b1, 32'h10, 1'b1, 32'h10, 32'hDEADBEEF); #1;
        check("t5_gnt", 32'(a_gnt), 32'd1);
        @(negedge clk); a_set(1'b1, 32'h10, 1'b1, 32'h11, 32'h12345678); #1;
        check("t5_old_rdata", a_rdata, 32'h0);
        check("t5_old_rvalid", 32'(a_rvalid), 32'd1);
        @(negedge clk); a_set(1'b0, 32'h0, 1'b0, 32'h0, 32'h0); #1;
        check("t5_new_rdata", a_rdata, 32'hDEADBEEF);
        @(negedge clk); #1;

        // latency 3, two outstanding
        exp_b[0] = 32'hA0; exp_b[1] = 32'hA1; exp_b[2] = 32'hA2;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); b_set(1'b0, 32'h0, 1'b1, 32'(4 * i), exp_b[i]); #1;
        end
        @(negedge clk); b_set(1'b1, 32'h0, 1'b0, 32'h0, 32'h0); #1;
        check("t2_c0_gnt", 32'(b_gnt), 32'd1);
        @(negedge clk); b_set(1'b1, 32'h4, 1'b0, 32'h0, 32'h0); #1;
        check("t2_c1_gnt", 32'(b_gnt), 32'd1);
        @(negedge clk); b_set(1'b1, 32'h8, 1'b0, 32'h0, 32'h0); #1;
        check("t2_c2_gnt", 32'(b_gnt), 32'd0);
        check("t2_c2_out", 32'(b_out), 32'd2);
        check("t2_c2_rvalid", 32'(b_rvalid), 32'd0);
        @(negedge clk); #1;
        check("t2_c3_gnt", 32'(b_gnt), 32'd1);
        check("t2_c3_rvalid", 32'(b_rvalid), 32'd1);
        check("t2_c3_rdata", b_rdata, exp_b[0]);
        @(negedge clk); b_set(1'b0, 32'h0, 1'b0, 32'h0, 32'h0); #1;
        check("t2_c4_rvalid", 32'(b_rvalid), 32'd1);
        check("t2_c4_rdata", b_rdata, exp_b[1]);
        @(negedge clk); #1;
        check("t2_c5_rvalid", 32'(b_rvalid), 32'd0);
        check("t2_c5_out", 32'(b_out), 32'd1);
        @(negedge clk); #1;
        check("t2_c6_rvalid", 32'(b_rvalid), 32'd1);
        check("t2_c6_rdata", b_rdata, exp_b[2]);
        check("t2_c6_err", 32'(b_err), 32'd0);
        @(negedge clk); #1;
        check("t2_c7_out", 32'(b_out), 32'd0);

        // grant gaps every two accepts
        gap_pat = 6'b011011;
        n_acc = 0;
        n_rsp = 0;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            c_req = (i < 6);
            #1;
            if (i < 6) begin
                check($sformatf("t4_gnt%0d", i), 32'(c_gnt), 32'(gap_pat[i]));
            end
            n_acc += int'(c_gnt);
            n_rsp += int'(c_rvalid);
        end
        check("t4_accepts", 32'(n_acc), 32'd4);
        check("t4_responses", 32'(n_rsp), 32'd4);
        check("t4_out", 32'(c_out), 32'd0);

        // reset with requests in flight
        @(negedge clk);
        b_set(1'b1, 32'h0, 1'b0, 32'h0, 32'h0);
        #1;
        @(negedge clk);
        b_set(1'b1, 32'h4, 1'b0, 32'h0, 32'h0);
        a_set(1'b1, 32'h10, 1'b0, 32'h0, 32'h0);
        #1;
        @(negedge clk);
        a_set(1'b1, 32'h0, 1'b0, 32'h0, 32'h0);
        #1;
        check("t6_pre_out_b", 32'(b_out), 32'd2);
        check("t6_pre_rvalid_a", 32'(a_rvalid), 32'd1);
        rstn = 1'b0;
        #1;
        check("t6_gnt_b", 32'(b_gnt), 32'd0);
        check("t6_gnt_a", 32'(a_gnt), 32'd0);
        check("t6_rvalid_a", 32'(a_rvalid), 32'd0);
        check("t6_out_b", 32'(b_out), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
        a_set(1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
        b_set(1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
        n_stale = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk); #1;
            n_stale += int'(a_rvalid) + int'(b_rvalid);
        end
        check("t6_stale_rvalid", 32'(n_stale), 32'd0);
        check("t6_post_out_b", 32'(b_out), 32'd0);
        @(negedge clk); a_set(1'b1, 32'h10, 1'b0, 32'h0, 32'h0); #1;
        check("t6_rb_gnt", 32'(a_gnt), 32'd1);
        @(negedge clk); a_set(1'b0, 32'h0, 1'b0, 32'h0, 32'h0); #1;
        check("t6_rb_rvalid", 32'(a_rvalid), 32'd1);
        check("t6_rb_rdata", a_rdata, 32'hDEADBEEF);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
